// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulated mechanical key (bounce, hold, bounce) on an active-low line.
// Optional press counter output press_cnt_o enabled by defining KEY_GEN_PRESS_CNT_EN.
module key_bounce_gen #(
    parameter int          CLK_FREQ_MHZ   = 150,
    parameter int          BOUNCE_TIME_NS = 200,
    parameter int          HOLD_TIME_NS   = 1000,
    parameter int          MAX_LOW_RUN    = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        press_req_i,
    output logic        ready_o,
    output logic        key_o,
`ifdef KEY_GEN_PRESS_CNT_EN
    output logic [15:0] press_cnt_o,
`endif
    output logic        press_done_stb_o
);
    localparam int BOUNCE_CYC = (CLK_FREQ_MHZ * BOUNCE_TIME_NS + 999) / 1000;
    localparam int HOLD_CYC   = (CLK_FREQ_MHZ * HOLD_TIME_NS + 999) / 1000;
    localparam int MAX_CYC    = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
    localparam int CW         = $clog2(MAX_CYC + 1);
    localparam int LW         = $clog2(MAX_LOW_RUN + 1);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    if (HOLD_CYC < 1) begin : g_hold_chk
        $error("HOLD_CYC must be >= 1");
    end
    if (MAX_LOW_RUN < 1) begin : g_run_chk
        $error("MAX_LOW_RUN must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BOUNCE_PRESS, HOLD, BOUNCE_REL} state_t;

    state_t          r_state;
    logic [15:0]     r_lfsr;
    logic [CW-1:0]   r_cnt;
    logic [LW-1:0]   r_low;
    logic            r_fin;
    logic            w_bkey;
    logic            w_fb;
    logic            w_b_last;
    logic            w_h_last;

    // A bounce cycle may not extend a low run past MAX_LOW_RUN.
    assign w_bkey   = r_lfsr[0] | (r_low == LW'(MAX_LOW_RUN));
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_b_last = r_cnt == CW'(BOUNCE_CYC - 1);
    assign w_h_last = r_cnt == CW'(HOLD_CYC - 1);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state          <= IDLE;
            key_o            <= 1'b1;
            ready_o          <= 1'b1;
            press_done_stb_o <= 1'b0;
            r_fin            <= 1'b0;
            r_lfsr           <= SEED;
            r_cnt            <= '0;
            r_low            <= '0;
`ifdef KEY_GEN_PRESS_CNT_EN
            press_cnt_o      <= 16'h0000;
`endif
        end else begin
            press_done_stb_o <= 1'b0;
`ifdef KEY_GEN_PRESS_CNT_EN
            if (r_state == IDLE && r_fin)
                press_cnt_o <= press_cnt_o + 16'h0001;
`endif
            case (r_state)
                IDLE: begin
                    key_o            <= 1'b1;
                    press_done_stb_o <= r_fin;
                    r_fin            <= 1'b0;
                    if (press_req_i) begin
                        r_state <= (BOUNCE_CYC == 0) ? HOLD : BOUNCE_PRESS;
                        ready_o <= 1'b0;
                        r_cnt   <= '0;
                        r_low   <= '0;
                    end
                end
                HOLD: begin
                    key_o <= 1'b0;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_h_last) begin
                        r_cnt   <= '0;
                        r_low   <= '0;
                        r_state <= (BOUNCE_CYC == 0) ? IDLE : BOUNCE_REL;
                        ready_o <= (BOUNCE_CYC == 0);
                        r_fin   <= (BOUNCE_CYC == 0);
                    end
                end
                default: begin
                    key_o  <= w_bkey;
                    r_lfsr <= {r_lfsr[14:0], w_fb};
                    r_low  <= w_bkey ? '0 : r_low + 1'b1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_b_last) begin
                        r_cnt   <= '0;
                        r_low   <= '0;
                        r_state <= (r_state == BOUNCE_PRESS) ? HOLD : IDLE;
                        ready_o <= (r_state == BOUNCE_REL);
                        r_fin   <= (r_state == BOUNCE_REL);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: scoreboard bench for key_bounce_gen (5-cycle bounce, 10-cycle hold).
module tb_key_bounce_gen;
    logic clk = 1'b0;
    logic srst_i = 1'b1;
    logic press_req_i = 1'b0;
    logic ready_o, key_o, press_done_stb_o;
`ifdef KEY_GEN_PRESS_CNT_EN
    logic [15:0] press_cnt_o;
`endif

    always #5 clk = ~clk;

    key_bounce_gen #(
        .CLK_FREQ_MHZ(100), .BOUNCE_TIME_NS(50), .HOLD_TIME_NS(100),
        .MAX_LOW_RUN(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk), .srst_i(srst_i), .press_req_i(press_req_i),
        .ready_o(ready_o), .key_o(key_o),
`ifdef KEY_GEN_PRESS_CNT_EN
        .press_cnt_o(press_cnt_o),
`endif
        .press_done_stb_o(press_done_stb_o)
    );

    typedef struct packed {logic key; logic stb; logic rdy; logic bnc;} exp_t;

    exp_t        q[$];
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_low = 0;
    int          n_tests = 0, n_fail = 0, n_stb = 0, cyc = 0, run = 0;
    int          stb_cyc[$];
    logic        en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bounce_bit(output logic b);
        b = m_lfsr[0] || (m_low == 2);
        m_low = b ? 0 : m_low + 1;
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    // Expected outputs for cycles 0..21 after an accepting edge.
    task automatic push_press(input logic back);
        logic b;
        q.push_back('{key: 1'b1, stb: back, rdy: 1'b0, bnc: 1'b0});
        m_low = 0;
        for (int k = 1; k <= 5; k++) begin
            bounce_bit(b);
            q.push_back('{key: b, stb: 1'b0, rdy: 1'b0, bnc: 1'b1});
        end
        for (int k = 6; k <= 15; k++)
            q.push_back('{key: 1'b0, stb: 1'b0, rdy: 1'b0, bnc: 1'b0});
        m_low = 0;
        for (int k = 16; k <= 20; k++) begin
            bounce_bit(b);
            q.push_back('{key: b, stb: 1'b0, rdy: (k == 20), bnc: 1'b1});
        end
        q.push_back('{key: 1'b1, stb: 1'b1, rdy: 1'b1, bnc: 1'b0});
    endtask

    task automatic step(input logic req, input logic rst);
        logic back;
        press_req_i = req;
        srst_i = rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            m_lfsr = 16'hACE1;
        end else if (req && q.size() <= 1) begin
            back = (q.size() == 1);
            if (back) void'(q.pop_front());
            push_press(back);
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, 1'b0);
        chk("idle_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (en) begin
            e = (q.size() > 0) ? q.pop_front() : '{key: 1'b1, stb: 1'b0, rdy: 1'b1, bnc: 1'b0};
            chk("key", key_o, e.key);
            chk("stb", press_done_stb_o, e.stb);
            chk("rdy", ready_o, e.rdy);
            if (e.bnc) begin
                run = key_o ? 0 : run + 1;
                chk("lowrun", run > 2, 0);
            end else
                run = 0;
            if (press_done_stb_o) begin
                n_stb++;
                stb_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int s0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        en = 1'b1;
        step(1'b0, 1'b0);
        // single press
        step(1'b1, 1'b0);
        wait_idle();
        chk("t1_strobes", n_stb, 1);
        // 50 presses against the reference LFSR
        for (int p = 0; p < 50; p++) begin
            step(1'b1, 1'b0);
            wait_idle();
        end
        chk("t2_strobes", n_stb, 51);
        // requests while busy are dropped
        step(1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) step(k == 3 || k == 12, 1'b0);
        wait_idle();
        chk("t3_strobes", n_stb, 52);
        // request held high: back-to-back presses
        s0 = stb_cyc.size();
        for (int i = 0; i < 200 && n_stb < 55; i++) step(1'b1, 1'b0);
        wait_idle();
        chk("t4_strobes", n_stb, 56);
        chk("t4_gap0", stb_cyc[s0 + 1] - stb_cyc[s0], 21);
        chk("t4_gap1", stb_cyc[s0 + 2] - stb_cyc[s0 + 1], 21);
        // reset in the middle of a press
        step(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);
        chk("t5_no_strobe", n_stb, 56);
        step(1'b1, 1'b0);
        wait_idle();
        chk("t5_strobes", n_stb, 57);
`ifdef KEY_GEN_PRESS_CNT_EN
        chk("press_cnt", press_cnt_o, 1);
`endif
        step(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
